// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared EX-stage encodings for the mul/div unit, ID decoder and hazard unit
package ex_pkg;

   // Operation select carried from the ID decoder
   typedef enum logic [1:0] {
      MD_MUL   = 2'b00,
      MD_MULHU = 2'b01,
      MD_DIVU  = 2'b10,
      MD_REMU  = 2'b11
   } md_op_t;

   // Mul/div unit control state, also observed by the hazard unit
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } md_state_t;

   // Divide ops share the op[1] bit
   function automatic logic md_is_div(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative unsigned multiply/divide unit for the EX stage
module ex_muldiv_unit
   import ex_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             busy
);

   md_state_t        state, state_nxt;
   md_op_t           op_q;
   logic [CNT_W-1:0] cnt;
   // hi: product upper half / partial remainder (extra bit keeps the trial sign)
   // lo: multiplier shifting out / dividend shifting out, quotient shifting in
   logic [WIDTH:0]   hi, hi_nxt;
   logic [WIDTH-1:0] lo, lo_nxt;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] final_res;
   logic [WIDTH:0]   add_sum, shifted, trial;
   logic [2*WIDTH:0] mul_cat;
   logic             accept, div_zero, last_step;

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign busy      = (state != S_IDLE);

   assign accept    = in_valid && in_ready && !flush;
   assign div_zero  = md_is_div(op) && (opb == '0);
   assign last_step = (cnt == CNT_W'(1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode; flush overrides every transition
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = div_zero ? S_DONE : S_BUSY;
         S_BUSY:  if (last_step) state_nxt = S_DONE;
         S_DONE:  if (out_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (flush) state_nxt = S_IDLE;
   end

   // One shift-add or restoring-divide step, selected by the latched op
   always_comb begin
      add_sum = {1'b0, hi[WIDTH-1:0]} + {1'b0, b_q};
      shifted = {hi[WIDTH-1:0], lo[WIDTH-1]};
      trial   = shifted - {1'b0, b_q};
      mul_cat = {(lo[0] ? add_sum : {1'b0, hi[WIDTH-1:0]}), lo};
      hi_nxt  = hi;
      lo_nxt  = lo;
      if (md_is_div(op_q)) begin
         if (!trial[WIDTH]) begin
            hi_nxt = trial;
            lo_nxt = {lo[WIDTH-2:0], 1'b1};
         end else begin
            hi_nxt = shifted;
            lo_nxt = {lo[WIDTH-2:0], 1'b0};
         end
      end else begin
         hi_nxt = {1'b0, mul_cat[2*WIDTH:WIDTH+1]};
         lo_nxt = mul_cat[WIDTH:1];
      end
      case (op_q)
         MD_MULHU, MD_REMU: final_res = hi_nxt[WIDTH-1:0];
         default:           final_res = lo_nxt;
      endcase
   end

   // Datapath: load on accept, step while busy, capture the result on the last step
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q   <= MD_MUL;
         cnt    <= '0;
         hi     <= '0;
         lo     <= '0;
         b_q    <= '0;
         result <= '0;
      end else if (accept) begin
         op_q <= md_op_t'(op);
         cnt  <= CNT_W'(WIDTH);
         hi   <= '0;
         lo   <= md_is_div(op) ? opa : opb;
         b_q  <= md_is_div(op) ? opb : opa;
         if (div_zero) result <= op[0] ? opa : '1;
      end else if (state == S_BUSY && !flush) begin
         hi  <= hi_nxt;
         lo  <= lo_nxt;
         cnt <= cnt - CNT_W'(1);
         if (last_step) result <= final_res;
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;
   import ex_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         flush = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [1:0]   op = 2'd0;
   logic [W-1:0] opa = '0;
   logic [W-1:0] opb = '0;
   logic         in_ready, out_valid, busy;
   logic [W-1:0] result;

   int  n_chk = 0;
   int  n_fail = 0;
   bit  chk_en = 1'b0;
   bit  done = 1'b0;

   bit          m_active = 1'b0;
   int          m_wait = 0;
   logic [31:0] m_exp = '0;

   ex_muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .opa(opa), .opb(opb),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_md(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
      logic [63:0] p;
      p = 64'(a) * 64'(b);
      case (o)
         2'd0:    return p[31:0];
         2'd1:    return p[63:32];
         2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      check(name, {31'b0, act}, {31'b0, exp});
   endtask

   // Reference: result value plus number of edges until the result appears
   initial forever begin
      @(posedge clk);
      if (rst || flush) begin
         m_active = 1'b0;
         m_wait   = 0;
      end else if (!m_active) begin
         if (in_valid) begin
            m_active = 1'b1;
            m_exp    = ref_md(op, opa, opb);
            m_wait   = (op[1] && opb == 0) ? 0 : W;
         end
      end else if (m_wait > 0) begin
         m_wait--;
      end else if (out_ready) begin
         m_active = 1'b0;
      end
   end

   // Compare DUT outputs against the reference every cycle
   initial forever begin
      @(negedge clk);
      if (chk_en && !done) begin
         check1("in_ready", in_ready, !m_active);
         check1("busy", busy, m_active);
         check1("out_valid", out_valid, m_active && m_wait == 0);
         if (m_active && m_wait == 0) check("result", result, m_exp);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      op = o; opa = a; opb = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; op = 2'($urandom); opa = $urandom; opb = $urandom;
   endtask

   task automatic wait_valid(output int lat);
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid) check1("timeout_out_valid", out_valid, 1'b1);
   endtask

   task automatic retire(input int hold);
      out_ready = 1'b0;
      repeat (hold) begin
         in_valid = 1'($urandom_range(0, 1));
         op = 2'($urandom); opa = $urandom; opb = $urandom;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check1("idle_after_retire", in_ready, 1'b1);
   endtask

   task automatic directed(input string name, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
      int lat;
      issue(o, a, b);
      wait_valid(lat);
      check(name, result, exp_res);
      check({name, "_latency"}, lat, exp_lat);
      retire(0);
   endtask

   task automatic abort_divide(input bit use_rst);
      issue(2'd2, 32'hDEAD_BEEF, 32'h0000_0123);
      repeat (11) begin @(posedge clk); #1; end
      if (use_rst) rst = 1'b1; else flush = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; flush = 1'b0;
      check1("abort_in_ready", in_ready, 1'b1);
      check1("abort_out_valid", out_valid, 1'b0);
      if (use_rst) check("reset_clears_result", result, 32'h0);
      repeat (40) begin @(posedge clk); #1; end
      directed("mul_3x3_after_abort", 2'd0, 32'd3, 32'd3, 32'd9, 33);
   endtask

   initial begin
      int lat;
      repeat (3) @(posedge clk);
      #1;
      check("reset_result", result, 32'h0);
      check1("reset_out_valid", out_valid, 1'b0);
      check1("reset_in_ready", in_ready, 1'b1);
      check1("reset_busy", busy, 1'b0);
      rst = 1'b0;
      chk_en = 1'b1;

      directed("mul_7x6",        2'd0, 32'd7,          32'd6,          32'h0000_002A, 33);
      directed("mulhu_max",      2'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 33);
      directed("mul_max",        2'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001, 33);
      directed("divu_100_7",     2'd2, 32'd100,        32'd7,          32'h0000_000E, 33);
      directed("remu_100_7",     2'd3, 32'd100,        32'd7,          32'h0000_0002, 33);
      directed("divu_msb_1",     2'd2, 32'h8000_0000,  32'd1,          32'h8000_0000, 33);
      directed("divu_by_zero",   2'd2, 32'd5,          32'd0,          32'hFFFF_FFFF, 1);
      directed("remu_by_zero",   2'd3, 32'd5,          32'd0,          32'h0000_0005, 1);
      directed("mul_zero_a",     2'd0, 32'd0,          32'h1234_5678,  32'h0,         33);
      directed("mulhu_zero_b",   2'd1, 32'hFFFF_FFFF,  32'd0,          32'h0,         33);

      issue(2'd0, 32'd12345, 32'd678);
      wait_valid(lat);
      retire(10);
      check("held_result_value", result, 32'd8_369_910);
      directed("accept_after_hold", 2'd3, 32'd1000, 32'd33, 32'd10, 33);

      in_valid = 1'b1; flush = 1'b1; op = 2'd0; opa = 32'd1; opb = 32'd1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      check1("flush_beats_in_valid", in_ready, 1'b1);

      abort_divide(1'b0);
      abort_divide(1'b1);

      for (int i = 0; i < 40; i++) begin
         logic [31:0] a, b;
         case ($urandom_range(0, 7))
            0:       a = 32'h0;
            1:       a = 32'hFFFF_FFFF;
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0:       b = 32'h0;
            1:       b = 32'hFFFF_FFFF;
            2:       b = $urandom_range(1, 255);
            default: b = $urandom;
         endcase
         issue(2'($urandom_range(0, 3)), a, b);
         wait_valid(lat);
         retire($urandom_range(0, 3));
      end

      repeat (2) @(posedge clk);
      done = 1'b1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
